// File: rtl/instr_fetch_responder.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_responder
// Description : Responder end of the instruction-fetch interface. Accepts word
//               addresses, reads a word-addressed instruction store through a
//               fixed-latency pipeline and returns 32-bit words, in order,
//               through a credit-protected response FIFO. A load port writes
//               the store at any time; flush discards all outstanding work.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_responder #(
   parameter int ADDR_BITS  = 8,
   parameter int LATENCY    = 2,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic [31:0]          req_addr,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [31:0]          rsp_data,
   output logic                 rsp_err,
   input  logic                 flush,
   input  logic                 ld_en,
   input  logic [ADDR_BITS-1:0] ld_addr,
   input  logic [31:0]          ld_data,
   output logic                 busy
);

   localparam int DEPTH = 1 << ADDR_BITS;
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
   // Wide enough for pipeline occupancy (<= 4) plus a full FIFO.
   localparam int SUM_W = CNT_W + 2;
   localparam int LAST  = LATENCY - 1;

   // ------------------------------------------------------------------------
   // Instruction store and request qualification
   // ------------------------------------------------------------------------
   logic [31:0]          store [DEPTH];

   logic                 accept;
   logic                 req_oor;

   // Read pipeline: stage s is index s-1; the last index is the read stage.
   logic [LATENCY-1:0]   pipe_valid;
   logic [LATENCY-1:0]   pipe_err;
   logic [ADDR_BITS-1:0] pipe_idx [LATENCY];

   logic [31:0]          rd_word;

   // Response FIFO
   logic [31:0]          fifo_data [FIFO_DEPTH];
   logic [FIFO_DEPTH-1:0] fifo_err;
   logic [PTR_W-1:0]     wr_ptr;
   logic [PTR_W-1:0]     rd_ptr;
   logic [CNT_W-1:0]     count;
   logic                 push;
   logic                 pop;

   // Credit accounting
   logic [SUM_W-1:0]     inflight;
   logic [SUM_W-1:0]     occupancy;

   assign accept  = req_valid & req_ready;
   // Any address bit above the store index puts the request out of range.
   assign req_oor = |req_addr[31:ADDR_BITS];

   // Load port: the write lands at the edge, so a same-cycle read sees the old word.
   always_ff @(posedge clk) begin
      if (ld_en) begin
         store[ld_addr] <= ld_data;
      end
   end

   // Advance the read pipeline every cycle; flush or reset kills every stage.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pipe_valid <= '0;
         pipe_err   <= '0;
         for (int s = 0; s < LATENCY; s++) begin
            pipe_idx[s] <= '0;
         end
      end else begin
         // accept is already low while flush is high (req_ready gated).
         pipe_valid[0] <= accept;
         pipe_err[0]   <= req_oor;
         pipe_idx[0]   <= req_addr[ADDR_BITS-1:0];
         for (int s = 1; s < LATENCY; s++) begin
            pipe_valid[s] <= pipe_valid[s-1] & ~flush;
            pipe_err[s]   <= pipe_err[s-1];
            pipe_idx[s]   <= pipe_idx[s-1];
         end
      end
   end

   // Final-stage combinational read; out-of-range requests return zero.
   assign rd_word = pipe_err[LAST] ? 32'h0 : store[pipe_idx[LAST]];

   // ------------------------------------------------------------------------
   // Response FIFO
   // ------------------------------------------------------------------------
   assign push = pipe_valid[LAST] & ~flush;
   assign pop  = rsp_valid & rsp_ready & ~flush;

   // FIFO payload storage; contents only matter while the slot is occupied.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_data[wr_ptr] <= rd_word;
         fifo_err[wr_ptr]  <= pipe_err[LAST];
      end
   end

   // FIFO pointers and occupancy; flush empties the queue and wins over push/pop.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         // Power-of-two depth: pointers wrap naturally.
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Head of the FIFO is presented directly; zero when nothing is queued.
   assign rsp_valid = (count != '0);
   assign rsp_data  = rsp_valid ? fifo_data[rd_ptr] : 32'h0;
   assign rsp_err   = rsp_valid & fifo_err[rd_ptr];

   // ------------------------------------------------------------------------
   // Credit: never accept more than the FIFO could ever hold
   // ------------------------------------------------------------------------
   // Count requests currently travelling down the pipeline.
   always_comb begin
      inflight = '0;
      for (int s = 0; s < LATENCY; s++) begin
         inflight = inflight + SUM_W'(pipe_valid[s]);
      end
   end

   assign occupancy = inflight + SUM_W'(count);

   // rst participates directly so ready drops the instant reset asserts.
   assign req_ready = rst & ~flush & (occupancy < SUM_W'(FIFO_DEPTH));

   assign busy = (|pipe_valid) | rsp_valid;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_fetch_responder
// Description : Self-checking bench for instr_fetch_responder. A queue-based
//               reference model predicts every response; a monitor compares
//               the DUT against it each cycle. Directed scenarios cover the
//               fetch, backpressure, range, flush, load-hazard and reset
//               cases, followed by a randomized soak.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_responder;

   localparam int AB          = 8;
   localparam int LAT         = 2;
   localparam int FD          = 4;
   localparam int STORE_WORDS = 1 << AB;

   logic          clk;
   logic          rst;
   logic          req_valid;
   logic          req_ready;
   logic [31:0]   req_addr;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [31:0]   rsp_data;
   logic          rsp_err;
   logic          flush;
   logic          ld_en;
   logic [AB-1:0] ld_addr;
   logic [31:0]   ld_data;
   logic          busy;

   instr_fetch_responder #(
      .ADDR_BITS  (AB),
      .LATENCY    (LAT),
      .FIFO_DEPTH (FD)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_addr  (req_addr),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data),
      .rsp_err   (rsp_err),
      .flush     (flush),
      .ld_en     (ld_en),
      .ld_addr   (ld_addr),
      .ld_data   (ld_data),
      .busy      (busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int vectors     = 0;
   int miscompares = 0;

   function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
      end
   endfunction

   // ------------------------------------------------------------------------
   // Reference model: requests wait LATENCY edges, then capture the store as
   // it stood just before that edge; the FIFO is a plain queue.
   // ------------------------------------------------------------------------
   typedef struct { logic [31:0] addr; int due; } pend_t;
   typedef struct { logic [31:0] data; logic err; } rsp_t;

   pend_t       pend[$];
   rsp_t        expq[$];
   logic [31:0] mstore [STORE_WORDS];
   int          nedge = 0;

   // Runs mid-cycle: inputs are stable and describe the upcoming rising edge.
   always @(negedge clk) begin
      int    occ;
      logic  exp_ready;
      pend_t p;
      rsp_t  r;
      if (!rst) begin
         pend.delete();
         expq.delete();
      end else begin
         occ       = pend.size() + expq.size();
         exp_ready = !flush && (occ < FD);
         check("req_ready", req_ready, exp_ready);
         check("busy", busy, occ != 0);
         check("rsp_valid", rsp_valid, expq.size() != 0);
         if (expq.size() != 0) begin
            check("rsp_data", rsp_data, expq[0].data);
            check("rsp_err", rsp_err, expq[0].err);
         end
         if (flush) begin
            pend.delete();
            expq.delete();
         end else begin
            if (expq.size() != 0 && rsp_ready) void'(expq.pop_front());
            while (pend.size() != 0 && pend[0].due == nedge) begin
               p      = pend.pop_front();
               r.err  = (p.addr >= 32'(STORE_WORDS));
               r.data = r.err ? 32'h0 : mstore[p.addr[AB-1:0]];
               expq.push_back(r);
            end
            if (req_valid && exp_ready) begin
               p.addr = req_addr;
               p.due  = nedge + LAT;
               pend.push_back(p);
            end
         end
      end
      if (ld_en) mstore[ld_addr] = ld_data;
      nedge++;
   end

   // ------------------------------------------------------------------------
   // Stimulus helpers
   // ------------------------------------------------------------------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle(input string nm);
      for (int k = 0; k < 100 && busy !== 1'b0; k++) tick();
      check(nm, busy, 1'b0);
   endtask

   // Wait (bounded) for a response, check it, and let it be consumed.
   task automatic expect_rsp(input string nm, input logic [31:0] d, input logic e);
      int k;
      k = 0;
      while (rsp_valid !== 1'b1 && k < 20) begin
         tick();
         k++;
      end
      check({nm, "_valid"}, rsp_valid, 1'b1);
      check({nm, "_data"}, rsp_data, d);
      check({nm, "_err"}, rsp_err, e);
      tick();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int acc;
      int a;
      rst       = 1'b0;
      req_valid = 1'b0;
      req_addr  = 32'h0;
      rsp_ready = 1'b0;
      flush     = 1'b0;
      ld_en     = 1'b0;
      ld_addr   = '0;
      ld_data   = 32'h0;

      // Reset state
      repeat (3) tick();
      check("rst_rsp_valid", rsp_valid, 1'b0);
      check("rst_rsp_data", rsp_data, 32'h0);
      check("rst_rsp_err", rsp_err, 1'b0);
      check("rst_req_ready", req_ready, 1'b0);
      check("rst_busy", busy, 1'b0);
      rst = 1'b1;

      // Program the whole store
      for (int i = 0; i < STORE_WORDS; i++) begin
         ld_en   = 1'b1;
         ld_addr = AB'(i);
         if (i < 4)       ld_data = 32'h11 * 32'(i + 1);
         else if (i == 5) ld_data = 32'h0000_AAAA;
         else             ld_data = $urandom;
         tick();
      end
      ld_en = 1'b0;

      // Basic back-to-back fetch with first-response latency
      rsp_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         req_valid = 1'b1;
         req_addr  = 32'(i);
         #1;
         check("basic_ready", req_ready, 1'b1);
         tick();
         #1;
         check("basic_latency", rsp_valid, i >= 2);
         if (i >= 2) check("basic_data", rsp_data, 32'h11 * 32'(i - 1));
      end
      req_valid = 1'b0;
      wait_idle("basic_idle");

      // Backpressure: exactly FIFO_DEPTH accepts, head held stable
      rsp_ready = 1'b0;
      acc = 0;
      a   = 0;
      for (int k = 0; k < 10; k++) begin
         req_valid = 1'b1;
         req_addr  = 32'(a);
         #1;
         if (req_ready) begin
            acc++;
            a++;
         end
         tick();
      end
      req_valid = 1'b0;
      #1;
      check("bp_accepts", acc, FD);
      check("bp_ready_low", req_ready, 1'b0);
      check("bp_head_valid", rsp_valid, 1'b1);
      check("bp_head_data", rsp_data, 32'h11);
      rsp_ready = 1'b1;
      wait_idle("bp_drain");
      check("bp_ready_back", req_ready, 1'b1);

      // Out-of-range request followed by a normal one
      req_valid = 1'b1;
      req_addr  = 32'h0000_0100;
      tick();
      req_addr  = 32'h1;
      tick();
      req_valid = 1'b0;
      expect_rsp("oor", 32'h0, 1'b1);
      expect_rsp("after_oor", 32'h22, 1'b0);
      wait_idle("oor_idle");

      // Flush one cycle after the third acceptance
      rsp_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         req_valid = 1'b1;
         req_addr  = 32'(i);
         tick();
      end
      req_addr = 32'h3;
      flush    = 1'b1;
      #1;
      check("flush_ready", req_ready, 1'b0);
      tick();
      flush     = 1'b0;
      req_valid = 1'b0;
      #1;
      check("flush_rsp_valid", rsp_valid, 1'b0);
      check("flush_busy", busy, 1'b0);
      rsp_ready = 1'b1;
      req_valid = 1'b1;
      req_addr  = 32'h3;
      tick();
      req_valid = 1'b0;
      expect_rsp("post_flush", 32'h44, 1'b0);
      wait_idle("flush_idle");

      // Load hazard: write lands on the edge where addr 5 is read
      req_valid = 1'b1;
      req_addr  = 32'h5;
      tick();
      req_valid = 1'b0;
      tick();
      ld_en     = 1'b1;
      ld_addr   = AB'(5);
      ld_data   = 32'h0000_BBBB;
      req_valid = 1'b1;
      req_addr  = 32'h5;
      tick();
      ld_en     = 1'b0;
      req_valid = 1'b0;
      expect_rsp("hazard_old", 32'h0000_AAAA, 1'b0);
      expect_rsp("hazard_new", 32'h0000_BBBB, 1'b0);
      wait_idle("hazard_idle");

      // Asynchronous reset with two in flight and one queued
      rsp_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         req_valid = 1'b1;
         req_addr  = 32'(i);
         tick();
      end
      req_valid = 1'b0;
      #1;
      rst = 1'b0;
      #1;
      check("arst_rsp_valid", rsp_valid, 1'b0);
      check("arst_req_ready", req_ready, 1'b0);
      check("arst_busy", busy, 1'b0);
      check("arst_rsp_data", rsp_data, 32'h0);
      tick();
      tick();
      rst       = 1'b1;
      rsp_ready = 1'b1;
      repeat (4) tick();
      check("arst_no_stale", rsp_valid, 1'b0);
      req_valid = 1'b1;
      req_addr  = 32'h0;
      tick();
      req_valid = 1'b0;
      expect_rsp("post_reset", 32'h11, 1'b0);
      wait_idle("reset_idle");

      // Randomized soak against the model
      for (int k = 0; k < 3000; k++) begin
         req_valid = ($urandom_range(3) != 0);
         case ($urandom_range(15))
            0:       req_addr = $urandom;
            1:       req_addr = 32'(STORE_WORDS);
            2:       req_addr = 32'(STORE_WORDS - 1);
            default: req_addr = 32'($urandom_range(STORE_WORDS - 1));
         endcase
         rsp_ready = ($urandom_range(2) != 0);
         flush     = ($urandom_range(39) == 0);
         ld_en     = ($urandom_range(7) == 0);
         ld_addr   = AB'($urandom_range(STORE_WORDS - 1));
         ld_data   = $urandom;
         tick();
      end
      req_valid = 1'b0;
      flush     = 1'b0;
      ld_en     = 1'b0;
      rsp_ready = 1'b1;
      wait_idle("soak_idle");
      check("soak_drained", pend.size() + expq.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/instr_fetch_responder.md
Name: instr_fetch_responder

Overview:
- Responder end of the instruction-fetch interface: accepts word addresses from the program counter / fetch initiator and returns 32-bit instruction words.
- Memory is word-addressable: address N selects 32-bit word N. The PC increments by 1 per instruction.
- Contains the instruction store, a fixed-latency read pipeline, and a response FIFO with backpressure.
- A load port lets the program be written in before or during execution.

Parameters:
- ADDR_BITS, 8, log2 of instruction store depth in words (store depth = 2^ADDR_BITS).
- LATENCY, 2, read pipeline stages from request acceptance to response push; legal range 1..4.
- FIFO_DEPTH, 4, response FIFO entries; power of two, at least 2.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- req_valid  in  1  fetch request valid.
- req_ready  out  1  responder can accept a request this cycle.
- req_addr  in  32  word address of the instruction to fetch.
- rsp_valid  out  1  rsp_data/rsp_err are valid.
- rsp_ready  in  1  consumer accepts the response this cycle.
- rsp_data  out  32  instruction word.
- rsp_err  out  1  request address was out of range.
- flush  in  1  discard all in-flight and queued responses (branch/redirect).
- ld_en  in  1  write ld_data into store at ld_addr.
- ld_addr  in  ADDR_BITS  load word address.
- ld_data  in  32  load data.
- busy  out  1  any request in flight or any response queued.

Behaviour:
- Reset (rst=0, asynchronous): pipeline valids cleared, FIFO empty, rsp_valid=0, rsp_data=0, rsp_err=0, req_ready=0, busy=0.
- Store contents are not reset.
- Accept condition: req_valid & req_ready at a rising edge.
- Credit rule: req_ready = rst & ~flush & (inflight + fifo_count < FIFO_DEPTH). A push can therefore never overflow the FIFO.
- Pipeline: an accepted request enters stage 1 with its address. Each stage advances unconditionally every cycle, with no stall.
- At the final stage the store is read combinationally and the result is pushed into the FIFO at the next edge.
- A request accepted at edge N is pushed at edge N+LATENCY; rsp_valid is high in the cycle after that edge. Minimum latency is LATENCY cycles.
- Range check: req_addr >= 2^ADDR_BITS (any upper bit set) gives rsp_data=0 and rsp_err=1. Otherwise rsp_err=0 and rsp_data = store[req_addr[ADDR_BITS-1:0]].
- Ordering: responses are returned strictly in acceptance order.
- FIFO output: rsp_valid = FIFO nonempty. rsp_data/rsp_err show the head entry and stay stable while rsp_valid & ~rsp_ready.
- Pop on rsp_valid & rsp_ready.
- Simultaneous push and pop is allowed at any occupancy, including full (count unchanged) and empty-with-push (no bypass; response is visible next cycle).
- Pointers wrap modulo FIFO_DEPTH.
- Flush, sampled at the edge:
  - Clears all pipeline valids and empties the FIFO.
  - Overrides any same-edge push or pop.
  - rsp_valid=0 and busy=0 in the following cycle.
  - A request presented during the flush cycle is not accepted (req_ready=0).
- Load:
  - The write takes effect at the edge.
  - A final-stage read of the same address in the same cycle returns the OLD word.
  - A read one cycle later returns the new word.
  - Loads never affect req_ready.
- busy = any pipeline valid | FIFO nonempty.
- Reset mid-operation: all in-flight and queued responses are dropped immediately, with no response emitted. Accepting resumes on the first edge after rst rises.

Test Plan:
- Basic fetch, LATENCY=2: load store[0..3]=32'h11,22,33,44; request addrs 0,1,2,3 back-to-back with rsp_ready=1 -> req_ready stays 1, rsp_valid first high 2 cycles after the first acceptance, data 11,22,33,44 in consecutive cycles, rsp_err=0.
- Backpressure: rsp_ready=0 and req_valid held high -> exactly FIFO_DEPTH=4 requests accepted, then req_ready=0. rsp_data stays 32'h11 while stalled. Raising rsp_ready drains 4 responses in order and req_ready returns to 1.
- Out of range: request 32'h0000_0100 with ADDR_BITS=8 -> rsp_err=1, rsp_data=0. The next request to addr 1 returns 32'h22 with rsp_err=0.
- Flush: accept addrs 0,1,2, pulse flush one cycle after the third acceptance -> none of the three responses appears, busy=0 the next cycle. The next request to addr 3 returns 32'h44.
- Load hazard: store[5]=32'hAAAA. Time ld_en writing 32'hBBBB to addr 5 on the same edge where the addr-5 request is in its final stage -> response 32'hAAAA. An immediate repeat request returns 32'hBBBB.
- Async reset mid-stream: drop rst to 0 between edges while 2 requests are in flight and 1 is queued -> rsp_valid, req_ready, busy go 0 without a clock edge. After rst=1, no stale responses appear and a new request to addr 0 returns 32'h11.
